// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between an instruction-fetch requester
// and a load/store requester.
//
// Handshake: a requester raises req with address/data and keeps them stable
// until it sees its gnt in the same cycle. The request is consumed on the
// rising edge that ends a gnt=1 cycle. A granted read answers with rvalid=1
// for exactly the following cycle. rdata keeps its last value otherwise.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   if_req/if_addr                fetch request (always a word read)
//   if_gnt/if_rvalid/if_rdata     fetch grant and read response
//   ls_req/ls_we/ls_bytes         load/store request, size code
//   ls_addr/ls_wdata              load/store address and store data
//   ls_gnt/ls_rvalid/ls_err       grant, load response valid, illegal size
//   ls_rdata                      load result
//   ram_addr/ram_wd/ram_bytes/ram_we  shared RAM request
//   ram_dout                      RAM read data (combinational)
module mem_arbiter #(
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_req,
  input  logic [A_WIDTH-1:0] if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [31:0]        if_rdata,
  input  logic               ls_req,
  input  logic               ls_we,
  input  logic [2:0]         ls_bytes,
  input  logic [A_WIDTH-1:0] ls_addr,
  input  logic [A_WIDTH-1:0] ls_wdata,
  output logic               ls_gnt,
  output logic               ls_rvalid,
  output logic               ls_err,
  output logic [31:0]        ls_rdata,
  output logic [A_WIDTH-1:0] ram_addr,
  output logic [A_WIDTH-1:0] ram_wd,
  output logic [2:0]         ram_bytes,
  output logic               ram_we,
  input  logic [31:0]        ram_dout
);

  localparam logic [2:0] SZ_WORD = 3'b010;

  // Which requester won most recently; the other one wins a contended cycle.
  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_LS = 1'b1
  } grant_e;

  grant_e last_grant;
  logic   ls_illegal;
  logic   ls_read;

  always_comb begin
    ls_illegal = (ls_bytes == 3'b011) || (ls_bytes == 3'b110) ||
                 (ls_bytes == 3'b111);
  end

  // Grant decision. Reset gates both grants so nothing reaches the RAM while
  // rst_n is low, even with requests pending.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (rst_n) begin
      if (if_req && ls_req) begin
        if (last_grant == GRANT_IF) ls_gnt = 1'b1;
        else                        if_gnt = 1'b1;
      end else begin
        if_gnt = if_req;
        ls_gnt = ls_req;
      end
    end
  end

  // An illegal size code is still granted (consumed) but flagged, never
  // writes and never produces a read response.
  always_comb begin
    ls_err  = ls_gnt && ls_illegal;
    ls_read = ls_gnt && !ls_we && !ls_illegal;
  end

  // RAM request mux; idle values when nothing usable is granted.
  always_comb begin
    ram_addr  = '0;
    ram_wd    = '0;
    ram_bytes = SZ_WORD;
    ram_we    = 1'b0;
    if (if_gnt) begin
      ram_addr = if_addr;
    end else if (ls_gnt && !ls_illegal) begin
      ram_addr  = ls_addr;
      ram_wd    = ls_wdata;
      ram_bytes = ls_bytes;
      ram_we    = ls_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_IF;
    end else if (if_gnt) begin
      last_grant <= GRANT_IF;
    end else if (ls_gnt) begin
      last_grant <= GRANT_LS;
    end
  end

  // Read responses: one cycle latency, data held between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      if_rvalid <= if_gnt;
      ls_rvalid <= ls_read;
      if (if_gnt)  if_rdata <= ram_dout;
      if (ls_read) ls_rdata <= ram_dout;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a byte-addressed RAM
// model (sign/zero extension done by the RAM, as seen on ram_dout).
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [2:0]  ls_bytes;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic        ls_err;
  logic [31:0] ls_rdata;
  logic [31:0] ram_addr;
  logic [31:0] ram_wd;
  logic [2:0]  ram_bytes;
  logic        ram_we;
  logic [31:0] ram_dout;

  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;
  logic [31:0] if_exp_q[$];
  logic [31:0] ls_exp_q[$];

  mem_arbiter #(.A_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_bytes(ls_bytes),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_err(ls_err),
    .ls_rdata(ls_rdata),
    .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_bytes(ram_bytes),
    .ram_we(ram_we), .ram_dout(ram_dout)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [7:0] mem [0:255];
  logic [7:0] ra, b0, b1, b2, b3;

  always_comb begin
    ra = ram_addr[7:0];
    b0 = mem[ra];
    b1 = mem[ra + 8'd1];
    b2 = mem[ra + 8'd2];
    b3 = mem[ra + 8'd3];
    case (ram_bytes)
      3'b000:  ram_dout = {{24{b0[7]}}, b0};
      3'b001:  ram_dout = {{16{b1[7]}}, b1, b0};
      3'b100:  ram_dout = {24'h0, b0};
      3'b101:  ram_dout = {16'h0, b1, b0};
      default: ram_dout = {b3, b2, b1, b0};
    endcase
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    mem[8'h10] <= 8'hEF; mem[8'h11] <= 8'hBE; mem[8'h12] <= 8'hAD; mem[8'h13] <= 8'hDE;
    mem[8'h30] <= 8'h78; mem[8'h31] <= 8'h56; mem[8'h32] <= 8'h34; mem[8'h33] <= 8'h12;
    mem[8'h24] <= 8'h11;
    mem[8'h28] <= 8'h22;
  end

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[7:0]] <= ram_wd[7:0];
      if (ram_bytes[1:0] != 2'b00) mem[ram_addr[7:0] + 8'd1] <= ram_wd[15:8];
      if (ram_bytes[1:0] == 2'b10) begin
        mem[ram_addr[7:0] + 8'd2] <= ram_wd[23:16];
        mem[ram_addr[7:0] + 8'd3] <= ram_wd[31:24];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every expected read response is queued at grant time and
  // must appear on the very next cycle.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      check("if_rvalid", {31'b0, if_rvalid}, {31'b0, (if_exp_q.size() != 0)});
      check("ls_rvalid", {31'b0, ls_rvalid}, {31'b0, (ls_exp_q.size() != 0)});
      if (if_exp_q.size() != 0) check("if_rdata", if_rdata, if_exp_q.pop_front());
      if (ls_exp_q.size() != 0) check("ls_rdata", ls_rdata, ls_exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_if(input logic req, input logic [31:0] addr);
    if_req  = req;
    if_addr = addr;
  endtask

  task automatic drive_ls(input logic req, input logic we, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd);
    ls_req   = req;
    ls_we    = we;
    ls_bytes = sz;
    ls_addr  = addr;
    ls_wdata = wd;
  endtask

  // Called just after a falling edge with inputs applied: checks the
  // combinational grant, queues expected read data, then advances one cycle.
  task automatic tick(input string tag, input logic e_if, input logic e_ls,
                      input logic e_err, input logic e_we,
                      input logic [31:0] if_d, input logic [31:0] ls_d);
    #1;
    check({tag, "/if_gnt"}, {31'b0, if_gnt}, {31'b0, e_if});
    check({tag, "/ls_gnt"}, {31'b0, ls_gnt}, {31'b0, e_ls});
    check({tag, "/ls_err"}, {31'b0, ls_err}, {31'b0, e_err});
    check({tag, "/ram_we"}, {31'b0, ram_we}, {31'b0, e_we});
    if (e_if) if_exp_q.push_back(if_d);
    if (e_ls && !e_we && !e_err) ls_exp_q.push_back(ls_d);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    drive_if(1'b1, 32'h10);
    drive_ls(1'b1, 1'b1, 3'b000, 32'h28, 32'hFF);
    #1 rst_n = 1'b0;

    // Requests (including a store) held during reset: nothing may be granted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst/if_gnt", {31'b0, if_gnt}, 32'h0);
      check("rst/ls_gnt", {31'b0, ls_gnt}, 32'h0);
      check("rst/ram_we", {31'b0, ram_we}, 32'h0);
    end
    check("rst/if_rvalid", {31'b0, if_rvalid}, 32'h0);
    check("rst/ls_rvalid", {31'b0, ls_rvalid}, 32'h0);
    check("rst/if_rdata", if_rdata, 32'h0);
    check("rst/ls_rdata", ls_rdata, 32'h0);
    check("rst/mem28", {24'h0, mem[8'h28]}, 32'h22);

    // Contention from the first cycle out of reset: ls, if, ls, if.
    drive_ls(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick("c1", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h12345678);
    tick("c2", 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
    tick("c3", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h12345678);
    tick("c4", 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0);

    // Idle bus values.
    drive_if(1'b0, 32'h0);
    drive_ls(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    #1;
    check("idle/ram_addr", ram_addr, 32'h0);
    check("idle/ram_bytes", {29'b0, ram_bytes}, 32'h2);
    check("idle/ram_wd", ram_wd, 32'h0);
    tick("idle1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Fetch only.
    drive_if(1'b1, 32'h10);
    #1;
    check("f/ram_addr", ram_addr, 32'h10);
    check("f/ram_bytes", {29'b0, ram_bytes}, 32'h2);
    tick("f1", 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
    drive_if(1'b0, 32'h0);
    tick("idle2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("hold/if_rdata", if_rdata, 32'hDEADBEEF);

    // Byte store then signed / unsigned byte loads.
    drive_ls(1'b1, 1'b1, 3'b000, 32'h20, 32'h80);
    #1;
    check("st/ram_addr", ram_addr, 32'h20);
    check("st/ram_wd", ram_wd, 32'h80);
    tick("st_b", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
    check("st/mem20", {24'h0, mem[8'h20]}, 32'h80);
    drive_ls(1'b1, 1'b0, 3'b000, 32'h20, 32'h0);
    tick("ld_b", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFFFF80);
    drive_ls(1'b1, 1'b0, 3'b100, 32'h20, 32'h0);
    tick("ld_bu", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h00000080);

    // Word store then half loads.
    drive_ls(1'b1, 1'b1, 3'b010, 32'h40, 32'hA5A51234);
    tick("st_w", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
    drive_ls(1'b1, 1'b0, 3'b001, 32'h40, 32'h0);
    tick("ld_h0", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h00001234);
    drive_ls(1'b1, 1'b0, 3'b001, 32'h42, 32'h0);
    tick("ld_h2", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFFA5A5);
    drive_ls(1'b1, 1'b0, 3'b101, 32'h42, 32'h0);
    tick("ld_hu", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000A5A5);
    drive_ls(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    tick("idle3", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("hold/ls_rdata", ls_rdata, 32'h0000A5A5);

    // Illegal size on a store: granted, flagged, no write.
    drive_ls(1'b1, 1'b1, 3'b111, 32'h24, 32'hFF);
    tick("ill_st", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    check("ill/mem24", {24'h0, mem[8'h24]}, 32'h11);

    // The illegal grant counts as ls being served, so fetch wins next.
    drive_if(1'b1, 32'h10);
    drive_ls(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    tick("post_ill", 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
    tick("post_ill2", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h12345678);

    // Illegal size on a load: no response.
    drive_if(1'b0, 32'h0);
    drive_ls(1'b1, 1'b0, 3'b011, 32'h30, 32'h0);
    tick("ill_ld", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    drive_ls(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    tick("idle4", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset right after a fetch response starts: cleared at once, nothing
    // arrives after release.
    drive_if(1'b1, 32'h10);
    #1;
    check("rr/if_gnt", {31'b0, if_gnt}, 32'h1);
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    check("rr/pre_rvalid", {31'b0, if_rvalid}, 32'h1);
    rst_n = 1'b0;
    drive_if(1'b0, 32'h0);
    #1;
    check("rr/if_rvalid", {31'b0, if_rvalid}, 32'h0);
    check("rr/if_rdata", if_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    if_exp_q.delete();
    ls_exp_q.delete();
    mon_en = 1'b1;
    tick("rr_idle1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick("rr_idle2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #3;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter A_WIDTH, default 32: address and write-data width.
REQ-002 Port clk  input  1: single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-004 Port if_req  input  1: fetch requester asks for a word read at if_addr.
REQ-005 Port if_addr  input  A_WIDTH: fetch byte address.
REQ-006 Port if_gnt  output  1: fetch request accepted this cycle.
REQ-007 Port if_rvalid  output  1: if_rdata valid this cycle.
REQ-008 Port if_rdata  output  32: fetched word.
REQ-009 Port ls_req  input  1: load/store requester asks for an access.
REQ-010 Port ls_we  input  1: 1 = store, 0 = load.
REQ-011 Port ls_bytes  input  3: size code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-012 Port ls_addr, ls_wdata  input  A_WIDTH each: byte address and store data.
REQ-013 Port ls_gnt, ls_rvalid, ls_err  output  1 each: accepted, load data valid, illegal size code.
REQ-014 Port ls_rdata  output  32: load result.
REQ-015 Ports ram_addr, ram_wd  output  A_WIDTH; ram_bytes  output  3; ram_we  output  1: shared RAM request.
REQ-016 Port ram_dout  input  32: RAM read data, combinational from ram_addr/ram_bytes.

Function
REQ-017 The block SHALL grant at most one requester per cycle; if_gnt and ls_gnt never both 1.
REQ-018 Grant is combinational in the request cycle; a requester holds req, address and data stable until it sees gnt.
REQ-019 Only one requester active: that requester is granted.
REQ-020 Both active: the one not granted most recently wins (1-bit last_grant register, updated on every grant).
REQ-021 last_grant resets to "fetch", so the first contended cycle after reset grants ls.
REQ-022 Fetch grant: ram_addr = if_addr, ram_bytes = 010, ram_we = 0.
REQ-023 LS grant: ram_addr = ls_addr, ram_bytes = ls_bytes, ram_wd = ls_wdata, ram_we = ls_we.
REQ-024 No grant: ram_we = 0, ram_bytes = 010, ram_addr = 0, ram_wd = 0.
REQ-025 Read grant in cycle N: ram_dout is registered at the end of cycle N; rdata is presented with rvalid = 1 for exactly cycle N+1 (latency 1).
REQ-026 rdata holds its last value while rvalid = 0.
REQ-027 Store grant in cycle N: RAM commits at the edge ending cycle N; ls_rvalid stays 0.
REQ-028 ls_bytes in {011, 110, 111}: ls_gnt = 1 and ls_err = 1 in that cycle, ram_we = 0, no read response; last_grant updates as for a normal grant.
REQ-029 Back-to-back grants allowed every cycle; e.g. fetch in N and ls in N+1 gives if_rvalid in N+1 and ls_rvalid in N+2.
REQ-030 While rst_n = 0, all gnt outputs and ram_we are forced to 0, regardless of requests.

Reset
REQ-031 Asynchronous on rst_n = 0: if_rvalid = 0, ls_rvalid = 0, if_rdata = 0, ls_rdata = 0, last_grant = fetch.
REQ-032 A read granted in the cycle before reset asserts SHALL NOT produce rvalid after release.
REQ-033 First grant is possible in the first cycle with rst_n = 1.

Verification
REQ-034 Fetch only: RAM word 0x0000_0010 = 0xDEADBEEF, if_req = 1, addr 0x10 -> if_gnt same cycle; next cycle if_rvalid = 1, if_rdata = 0xDEADBEEF.
REQ-035 Contention after reset: if_req and ls_req held for 4 cycles -> grants ls, if, ls, if; each rvalid one cycle after its grant.
REQ-036 Store then load: ls_we = 1, bytes 000, addr 0x20, wdata 0x80; then a load with bytes 000 at 0x20 -> ls_rdata = 0xFFFFFF80; load with bytes 100 at 0x20 -> 0x00000080.
REQ-037 Illegal code: ls_bytes = 111 with ls_we = 1 -> ls_gnt = 1, ls_err = 1, ram_we = 0, memory unchanged, no ls_rvalid.
REQ-038 Reset mid-read: fetch granted in cycle N, rst_n low during cycle N+1 -> if_rvalid = 0 and if_rdata = 0 immediately; no response after release.
REQ-039 Reset with pending store request: ls_req = 1, ls_we = 1 while rst_n = 0 -> ram_we = 0 throughout; target byte unchanged.
